// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the SRAM responder slice.
package ahb_pkg;

  localparam int unsigned AHB_DATA_W = 128;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1
  } hburst_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_state_t;

endpackage

// File: rtl/ahb_slave_mem.sv
// DEPTH x 128-bit word store: async clear, one write port, combinational read.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [AHB_DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [AHB_DATA_W-1:0] rdata_o
);

  logic [AHB_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder storing 128-bit beats in a word array, with optional
// wait states and a two-cycle ERROR response for illegal addresses.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         HSEL,
  input  logic [31:0]  HADDR,
  input  logic [1:0]   HTRANS,
  input  logic         HWRITE,
  input  logic [2:0]   HBURST,
  input  logic [127:0] HWDATA,
  output logic [127:0] HRDATA,
  output logic         HREADY,
  output logic         HRESP,
  output logic [15:0]  wr_count
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  WS_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  slave_state_t          state_q, state_d;
  logic                  write_q, write_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            wcnt_q, wcnt_d;
  logic [15:0]           wr_count_q;
  logic [31:0]           offset;
  logic                  accept, legal, mem_we;
  logic [AHB_DATA_W-1:0] mem_rdata;
  logic                  unused_ok;

  // Unsigned wrap makes addresses below BASE_ADDR huge; the >= test rejects them.
  assign offset = HADDR - BASE_ADDR;
  assign legal  = (HADDR[3:0] == 4'h0) && (HADDR >= BASE_ADDR) &&
                  ({4'h0, offset[31:4]} < DEPTH);
  assign accept = HSEL && HREADY &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign unused_ok = ^{HBURST, offset[3:0]};

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_WAIT: begin
        if (wcnt_q == 2'd0) state_d = ST_DATA;
        else                wcnt_d  = wcnt_q - 2'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all present HREADY=1 and accept the next beat.
        state_d = ST_IDLE;
        if (accept) begin
          write_d = HWRITE;
          idx_d   = offset[4 +: IDX_W];
          if (!legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            wcnt_d  = WS_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      idx_q      <= '0;
      wcnt_q     <= '0;
      wr_count_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      if (mem_we && (wr_count_q != '1)) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign mem_we = (state_q == ST_DATA) && write_q;

  ahb_slave_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (n_rst),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (HWDATA),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

  assign HREADY   = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign HRESP    = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA   = ((state_q == ST_DATA) && !write_q) ? mem_rdata : '0;
  assign wr_count = wr_count_q;

endmodule
